// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M execute unit.
// Multiplies finish in one compute cycle. Divides and remainders use a
// 32-step radix-2 restoring loop. Results leave over a valid/ready pair
// together with their destination tag.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               kills any in-flight op or held result (redirect)
//   in_valid/in_ready   op handshake; in_ready is high only while idle
//   a, b, mode, in_tag  operands, RV32M op select, destination tag
//   out_valid/out_ready result handshake
//   q, out_tag          result and its tag, stable while out_valid is held
//
// mode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//       100 DIV, 101 DIVU, 110 REM,    111 REMU
//
// Build option: define MULDIV_FAST_SPECIAL_EN so that divide-by-zero and
// signed overflow resolve in the setup cycle (1-edge latency). Without it
// every divide takes 34 edges. Results are identical either way.
module muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [2:0]       mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  q,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W     = 6;
    localparam int unsigned PROD_W    = 2 * XLEN;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_SETUP,
        S_DIV_ITER,
        S_DIV_FIX,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [XLEN-1:0]  op_a, op_b;
    logic [2:0]       op_mode;
    logic [TAG_W-1:0] op_tag;
    logic [XLEN-1:0]  quo, rem, dvs;
    logic             neg_q, neg_r;
    logic [CNT_W-1:0] cnt;

    // Operand classification for divide-type ops
    logic            signed_div, is_rem, b_zero, div_ovf, special;
    logic [XLEN-1:0] special_q;
    logic            sa, sb;
    logic [XLEN-1:0] a_abs, b_abs;

    always_comb begin
        signed_div = ~op_mode[0];
        is_rem     = op_mode[1];
        b_zero     = (op_b == '0);
        div_ovf    = signed_div && (op_a == MIN_NEG) && (op_b == '1);
        special    = b_zero || div_ovf;
        if (b_zero) begin
            special_q = is_rem ? op_a : '1;
        end else begin
            special_q = is_rem ? '0 : MIN_NEG;
        end
        sa    = signed_div && op_a[XLEN-1];
        sb    = signed_div && op_b[XLEN-1];
        a_abs = sa ? -op_a : op_a;
        b_abs = sb ? -op_b : op_b;
    end

    // Multiply: extend each operand per its signedness, keep 2*XLEN bits
    logic              a_sx, b_sx;
    logic [PROD_W-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   mul_q;

    always_comb begin
        a_sx  = ((op_mode == 3'b001) || (op_mode == 3'b010)) && op_a[XLEN-1];
        b_sx  = (op_mode == 3'b001) && op_b[XLEN-1];
        a_ext = {{XLEN{a_sx}}, op_a};
        b_ext = {{XLEN{b_sx}}, op_b};
        prod  = a_ext * b_ext;
        mul_q = (op_mode[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PROD_W-1:XLEN];
    end

    // One restoring step: shift next dividend bit into the partial remainder
    logic [XLEN:0]   rem_sh;
    logic            step_ge;
    logic [XLEN-1:0] step_diff;
    logic [XLEN-1:0] quo_s, rem_s, fix_q;

    always_comb begin
        rem_sh    = {rem, quo[XLEN-1]};
        step_ge   = (rem_sh >= {1'b0, dvs});
        // When the subtraction succeeds the true difference is below dvs,
        // so the low XLEN bits are exact.
        step_diff = rem_sh[XLEN-1:0] - dvs;
        quo_s     = neg_q ? -quo : quo;
        rem_s     = neg_r ? -rem : rem;
        if (special) begin
            fix_q = special_q;
        end else begin
            fix_q = is_rem ? rem_s : quo_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; flush overrides everything including an accept
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_n = mode[2] ? S_DIV_SETUP : S_MUL;
                end
            end
            S_MUL:       state_n = S_DONE;
            S_DIV_SETUP: begin
`ifdef MULDIV_FAST_SPECIAL_EN
                state_n = special ? S_DONE : S_DIV_ITER;
`else
                state_n = S_DIV_ITER;
`endif
            end
            S_DIV_ITER: begin
                if (cnt == LAST_ITER) begin
                    state_n = S_DIV_FIX;
                end
            end
            S_DIV_FIX:   state_n = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default:     state_n = S_IDLE;
        endcase
        if (flush) begin
            state_n = S_IDLE;
        end
    end

    assign in_ready = (state == S_IDLE);

    // Datapath and registered outputs; result loads only when DONE is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_mode   <= '0;
            op_tag    <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            q         <= '0;
            out_tag   <= '0;
        end else begin
            out_valid <= (state_n == S_DONE);
            case (state)
                S_IDLE: begin
                    if (state_n != S_IDLE) begin
                        op_a    <= a;
                        op_b    <= b;
                        op_mode <= mode;
                        op_tag  <= in_tag;
                    end
                end
                S_MUL: begin
                    if (state_n == S_DONE) begin
                        q       <= mul_q;
                        out_tag <= op_tag;
                    end
                end
                S_DIV_SETUP: begin
                    quo   <= a_abs;
                    dvs   <= b_abs;
                    rem   <= '0;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    cnt   <= '0;
                    if (state_n == S_DONE) begin
                        q       <= special_q;
                        out_tag <= op_tag;
                    end
                end
                S_DIV_ITER: begin
                    quo <= {quo[XLEN-2:0], step_ge};
                    rem <= step_ge ? step_diff : rem_sh[XLEN-1:0];
                    if (cnt != LAST_ITER) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIV_FIX: begin
                    if (state_n == S_DONE) begin
                        q       <= fix_q;
                        out_tag <= op_tag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases with literal
// results, hold/flush/reset scenarios, then randomized ops compared against
// an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] q;
    logic [4:0]  out_tag;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q = '0;
    logic [4:0]  exp_tag = '0;
    logic        exp_pending = 1'b0;

    muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] m, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        r  = '0;
        case (m)
            3'd0: begin p = sx * sy; r = p[31:0];  end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFFFFFF;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
                else begin p = sx / sy; r = p[31:0]; end
            end
            3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h0;
                else begin p = sx % sy; r = p[31:0]; end
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] m, input logic [31:0] x,
                                   input logic [31:0] y);
        int l;
        l = m[2] ? 34 : 1;
`ifdef MULDIV_FAST_SPECIAL_EN
        if (m[2] && (y == 0 || (!m[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) l = 1;
`else
        if (x == y && x == 32'h1234_5678) l = l;
`endif
        return l;
    endfunction

    // Compare process: every cycle a result is presented it must be expected
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("mon_pending", 32'(exp_pending), 32'd1);
            chk("mon_q", q, exp_q);
            chk("mon_tag", 32'(out_tag), 32'(exp_tag));
            chk("mon_busy_ready", 32'(in_ready), 32'd0);
        end
    end

    task automatic run_op(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] t, input int hold, input bit use_lit,
                          input logic [31:0] lit);
        int lat;
        @(negedge clk);
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        mode = m; a = av; b = bv; in_tag = t; in_valid = 1'b1;
        exp_q = model(m, av, bv);
        exp_tag = t;
        exp_pending = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs so any resampling shows up as a wrong result
        in_valid = 1'b0; a = $urandom; b = $urandom;
        mode = 3'($urandom); in_tag = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 60) begin
            chk("busy_not_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat(m, av, bv)));
        if (use_lit) chk("literal_q", q, lit);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_not_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_pending = 1'b0;
        chk("released_valid", 32'(out_valid), 32'd0);
        chk("released_ready", 32'(in_ready), 32'd1);
    endtask

    // Start a DIVU and kill it by flush or reset while iteration `iter` runs
    task automatic abort_div(input bit use_rst, input int iter);
        @(negedge clk);
        mode = 3'b101; a = 32'hDEADBEEF; b = 32'd13; in_tag = 5'd9; in_valid = 1'b1;
        exp_pending = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (iter + 1) @(posedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush = 1'b0;
        chk(use_rst ? "rst_ready" : "flush_ready", 32'(in_ready), 32'd1);
        chk(use_rst ? "rst_valid" : "flush_valid", 32'(out_valid), 32'd0);
        if (use_rst) begin
            chk("rst_q", q, 32'd0);
            chk("rst_tag", 32'(out_tag), 32'd0);
        end
        repeat (40) @(negedge clk);
        chk("abort_still_idle", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'hFFFFFFFF;
            2: v = 32'h80000000;
            3: v = 32'h1;
            4: v = 32'($urandom_range(0, 100));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_q", q, 32'd0);
        chk("reset_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiplies
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd4, 0, 1'b1, 32'hFFFFFFEB);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 0, 1'b1, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 0, 1'b1, 32'h00000000);
        // Divides
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 0, 1'b1, 32'hFFFFFFFD);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 0, 1'b1, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 0, 1'b1, 32'd2);
        // Special cases
        run_op(3'd4, 32'd5, 32'd0, 5'd10, 0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd4, 32'hFFFFFFFB, 32'd0, 5'd11, 0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd6, 32'hFFFFFFFB, 32'd0, 5'd12, 0, 1'b1, 32'hFFFFFFFB);
        run_op(3'd5, 32'd77, 32'd0, 5'd13, 0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd7, 32'd77, 32'd0, 5'd14, 0, 1'b1, 32'd77);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 0, 1'b1, 32'h80000000);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 0, 1'b1, 32'h00000000);

        // Long hold on the result, then back-to-back op
        run_op(3'd5, 32'd1000, 32'd3, 5'd17, 10, 1'b1, 32'd333);
        run_op(3'd0, 32'd6, 32'd7, 5'd18, 0, 1'b1, 32'd42);

        // Flush mid-divide, then reset mid-divide; each followed by a good op
        abort_div(1'b0, 15);
        run_op(3'd5, 32'hDEADBEEF, 32'd13, 5'd19, 0, 1'b0, 32'd0);
        abort_div(1'b1, 20);
        run_op(3'd6, 32'hFFFFFF9C, 32'd7, 5'd20, 0, 1'b1, 32'hFFFFFFFE);

        // Flush on the same edge as an offered op: op must not be taken
        @(negedge clk);
        mode = 3'd0; a = 32'd3; b = 32'd5; in_tag = 5'd21; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_ignored", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom), pick(), pick(), 5'($urandom), $urandom_range(0, 3),
                   1'b0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
